effect_compressor: RTL and testbench

- Second stage of the per-sample effect chain; sits directly downstream of the noise gate and consumes its 16-bit output sample with a one-cycle valid strobe.
- Applies a fixed 2:1 hard-knee compressor. Threshold comes from the 3-bit compressor level set in SET mode; gain is driven by an attack/release peak envelope follower.
- Produces a registered sample and a valid strobe for the next effect stage (distortion).

---
 rtl/effect_compressor.sv | 197 +++++++++++++++++++
 tb/tb_effect_compressor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/effect_compressor.sv
// 2:1 hard-knee compressor stage: peak envelope follower, 16-cycle restoring
// divider for the gain, and one multiply per sample. Fixed 19-cycle latency.
`timescale 1ns/1ps

module effect_compressor #(
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic               i_enable,
  input  logic [2:0]         i_level,
  input  logic signed [15:0] i_data,
  output logic signed [15:0] o_data,
  output logic               o_valid,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ENV  = 3'd1,
    ST_DIV  = 3'd2,
    ST_MUL  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  // |x| with the most negative code pinned to full-scale positive
  function automatic logic [15:0] abs_sat(input logic signed [15:0] x);
    logic [15:0] r;
    if (x[15] && (x[14:0] == 15'd0)) begin
      r = 16'd32767;
    end else if (x[15]) begin
      r = $unsigned(-x);
    end else begin
      r = $unsigned(x);
    end
    return r;
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [33:0] x);
    logic signed [15:0] r;
    if (x > 34'sd32767) begin
      r = 16'sh7fff;
    end else if (x < -34'sd32768) begin
      r = 16'sh8000;
    end else begin
      r = $signed(x[15:0]);
    end
    return r;
  endfunction

  state_t             state_r;
  logic signed [15:0] sample_r;
  logic               enable_r;
  logic [2:0]         level_r;
  logic [15:0]        abs_r;
  logic [15:0]        env_r;
  logic               unity_r;
  logic [15:0]        rem_r;
  logic               lsb_r;
  logic [3:0]         div_cnt_r;
  logic [16:0]        gain_r;

  logic [15:0]        env_next_s;
  logic [15:0]        thresh_s;
  logic [15:0]        target_s;
  logic               unity_s;
  logic               in_bit_s;
  logic [16:0]        rem_shift_s;
  logic [15:0]        rem_next_s;
  logic               qbit_s;
  logic signed [33:0] product_s;
  logic signed [33:0] result_s;

  // Envelope update, threshold and compressed target for the captured sample
  always_comb begin
    env_next_s = env_r;
    target_s   = 16'd0;
    unity_s    = 1'b1;
    if (abs_r > env_r) begin
      env_next_s = env_r + ((abs_r - env_r) >> ATTACK_SHIFT);
    end else if (abs_r < env_r) begin
      env_next_s = env_r - ((env_r - abs_r) >> RELEASE_SHIFT);
    end else begin
      env_next_s = env_r;
    end
    thresh_s = 16'h8000 >> ({1'b0, level_r} + 4'd1);
    if (env_next_s > thresh_s) begin
      target_s = thresh_s + ((env_next_s - thresh_s) >> 1);
      unity_s  = 1'b0;
    end else begin
      target_s = 16'd0;
      unity_s  = 1'b1;
    end
  end

  // One restoring-division step; the first step shifts in target[0] and
  // yields the integer quotient bit, the other fifteen the Q1.15 fraction
  always_comb begin
    in_bit_s    = (div_cnt_r == 4'd0) ? lsb_r : 1'b0;
    rem_shift_s = {rem_r, in_bit_s};
    rem_next_s  = rem_shift_s[15:0];
    qbit_s      = 1'b0;
    if (rem_shift_s >= {1'b0, env_r}) begin
      rem_next_s = 16'(rem_shift_s - {1'b0, env_r});
      qbit_s     = 1'b1;
    end else begin
      rem_next_s = rem_shift_s[15:0];
      qbit_s     = 1'b0;
    end
  end

  // Gain multiply with floor rounding, or straight pass-through in bypass
  always_comb begin
    product_s = $signed({{18{sample_r[15]}}, sample_r}) * $signed({17'd0, gain_r});
    if (enable_r) begin
      result_s = product_s >>> 15;
    end else begin
      result_s = {{18{sample_r[15]}}, sample_r};
    end
  end

  // Sample sequencer and all state registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      sample_r  <= 16'sd0;
      enable_r  <= 1'b0;
      level_r   <= 3'd0;
      abs_r     <= 16'd0;
      env_r     <= 16'd0;
      unity_r   <= 1'b0;
      rem_r     <= 16'd0;
      lsb_r     <= 1'b0;
      div_cnt_r <= 4'd0;
      gain_r    <= 17'd0;
      o_data    <= 16'sd0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          o_valid <= 1'b0;
          if (i_valid) begin
            sample_r <= i_data;
            enable_r <= i_enable;
            level_r  <= i_level;
            abs_r    <= abs_sat(i_data);
            o_busy   <= 1'b1;
            state_r  <= ST_ENV;
          end
        end
        ST_ENV: begin
          env_r     <= env_next_s;
          unity_r   <= unity_s;
          rem_r     <= target_s >> 1;
          lsb_r     <= target_s[0];
          gain_r    <= 17'd0;
          div_cnt_r <= 4'd0;
          state_r   <= ST_DIV;
        end
        ST_DIV: begin
          rem_r     <= rem_next_s;
          div_cnt_r <= div_cnt_r + 4'd1;
          if (div_cnt_r == 4'd15) begin
            // unity and env=0 still spend the full 16 cycles
            if (unity_r || (env_r == 16'd0)) begin
              gain_r <= 17'd32768;
            end else begin
              gain_r <= {gain_r[15:0], qbit_s};
            end
            state_r <= ST_MUL;
          end else begin
            gain_r <= {gain_r[15:0], qbit_s};
          end
        end
        ST_MUL: begin
          o_data  <= sat16(result_s);
          o_valid <= 1'b1;
          state_r <= ST_OUT;
        end
        ST_OUT: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_effect_compressor.sv
// Scoreboard bench for effect_compressor: stimulus pushes expected samples,
// a negedge monitor pops and compares on every o_valid strobe.
`timescale 1ns/1ps

module tb_effect_compressor;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_valid;
  logic               i_enable;
  logic [2:0]         i_level;
  logic signed [15:0] i_data;
  logic signed [15:0] o_data;
  logic               o_valid;
  logic               o_busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int env_m  = 0;
  int exp_q[$];
  logic prev_valid = 1'b0;

  effect_compressor #(.ATTACK_SHIFT(2), .RELEASE_SHIFT(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_enable(i_enable),
    .i_level(i_level), .i_data(i_data), .o_data(o_data), .o_valid(o_valid),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: envelope follower plus exact integer gain math
  function automatic int model_step(input int data, input bit en, input int lvl);
    int a, t, tgt, r;
    longint g, p;
    a = (data < 0) ? -data : data;
    if (a > 32767) a = 32767;
    if (a > env_m) env_m = env_m + ((a - env_m) >> 2);
    else if (a < env_m) env_m = env_m - ((env_m - a) >> 8);
    t = 32768 >> (lvl + 1);
    if (!en || env_m <= t) begin
      r = data;
    end else begin
      tgt = t + ((env_m - t) >> 1);
      g = (longint'(tgt) * 64'sd32768) / longint'(env_m);
      p = longint'(data) * g;
      r = int'(p >>> 15);
    end
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // Monitor: every strobe must match the oldest expected sample
  always @(negedge i_clk) begin
    if (i_rst === 1'b0 && o_valid === 1'b1) begin
      check("o_valid_single_cycle", int'(prev_valid), 0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_strobe: o_data %0d with empty scoreboard", o_data);
      end else begin
        check("o_data", int'(o_data), exp_q.pop_front());
      end
    end
    prev_valid <= (o_valid === 1'b1);
  end

  // Issue one sample at the current negedge and wait out its 20-cycle slot
  task automatic send(input int data, input bit en, input int lvl, input int exp);
    i_valid  = 1'b1;
    i_data   = 16'(data);
    i_enable = en;
    i_level  = 3'(lvl);
    exp_q.push_back(exp);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (19) @(negedge i_clk);
  endtask

  task automatic send_model(input int data, input bit en, input int lvl);
    send(data, en, lvl, model_step(data, en, lvl));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_exp;
    i_rst = 1'b1; i_valid = 1'b0; i_enable = 1'b1; i_level = 3'd0; i_data = 16'sd0;
    @(negedge i_clk);

    // 1. reset held with a valid sample present
    i_valid = 1'b1; i_data = 16'sd500;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      check("rst_o_data", int'(o_data), 0);
      check("rst_o_valid", int'(o_valid), 0);
      check("rst_o_busy", int'(o_busy), 0);
    end
    i_rst = 1'b0; i_valid = 1'b0;
    repeat (25) @(negedge i_clk);
    check("post_rst_busy", int'(o_busy), 0);

    // reset mid-sample aborts it
    i_valid = 1'b1; i_data = 16'sd20000; i_enable = 1'b1; i_level = 3'd2;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    check("mid_busy", int'(o_busy), 1);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    env_m = 0;
    repeat (25) @(negedge i_clk);
    check("abort_busy", int'(o_busy), 0);

    // 2. bypass latency, busy window, hold
    void'(model_step(-12345, 1'b0, 0));
    exp_q.push_back(-12345);
    for (int c = 0; c <= 21; c++) begin
      if (c == 0) begin
        i_valid = 1'b1; i_data = -16'sd12345; i_enable = 1'b0; i_level = 3'd0;
      end else begin
        i_valid = 1'b0;
      end
      check($sformatf("byp_busy_c%0d", c), int'(o_busy), (c >= 1 && c <= 19) ? 1 : 0);
      check($sformatf("byp_valid_c%0d", c), int'(o_valid), (c == 19) ? 1 : 0);
      if (c >= 19) check($sformatf("byp_hold_c%0d", c), int'(o_data), -12345);
      @(negedge i_clk);
    end

    // 3. below threshold: bit-exact unity
    for (int i = 0; i < 100; i++) begin
      int d;
      d = (i < 50) ? 1000 : -1000;
      void'(model_step(d, 1'b1, 0));
      send(d, 1'b1, 0, d);
    end

    // 4. steady compression at level 3
    for (int i = 0; i < 63; i++) send_model(16000, 1'b1, 3);
    void'(model_step(16000, 1'b1, 3));
    send(16000, 1'b1, 3, 9023);

    // 5. saturated negative full scale at level 7
    for (int i = 0; i < 64; i++) send_model(-32768, 1'b1, 7);
    last_exp = model_step(-32768, 1'b1, 7);
    send(-32768, 1'b1, 7, last_exp);

    // 6. collision: second strobe at cycle 5 is dropped
    exp_q.push_back(model_step(30000, 1'b1, 7));
    for (int c = 0; c <= 20; c++) begin
      if (c == 0) begin
        i_valid = 1'b1; i_data = 16'sd30000; i_enable = 1'b1; i_level = 3'd7;
      end else if (c == 5) begin
        i_valid = 1'b1; i_data = 16'sd7777; i_enable = 1'b0; i_level = 3'd0;
      end else begin
        i_valid = 1'b0;
      end
      if (c == 18 || c == 19 || c == 20)
        check($sformatf("coll_valid_c%0d", c), int'(o_valid), (c == 19) ? 1 : 0);
      if (c == 20) check("coll_busy_c20", int'(o_busy), 0);
      @(negedge i_clk);
    end

    // release: mostly silence with occasional probes of the decaying envelope
    for (int i = 0; i < 200; i++) send_model((i % 25 == 24) ? 3000 : 0, 1'b1, 7);

    repeat (10) @(negedge i_clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
